// File: rtl/synaptic_current_accumulator_if.sv
// Request/response bundle between a spike requester and the synaptic current accumulator.
// The requester owns start, spikes and weights; the accumulator owns status and result.
interface synaptic_current_accumulator_if #(
  parameter int M  = 24,
  parameter int W  = 8,
  parameter int OW = 8
);
  logic              start;
  logic [M-1:0]      input_spikes;
  logic [M*W-1:0]    weights;
  logic              busy;
  logic              done;
  logic [OW-1:0]     input_current;
  logic              saturated;

  modport master (
    output start, input_spikes, weights,
    input  busy, done, input_current, saturated
  );

  modport slave (
    input  start, input_spikes, weights,
    output busy, done, input_current, saturated
  );
endinterface

// File: rtl/synaptic_current_accumulator.sv
// Gated signed weight accumulation over M synapses, P lanes per cycle,
// with a saturated OW-bit result and a one-cycle done pulse.
module synaptic_current_accumulator #(
  parameter int M  = 24,
  parameter int W  = 8,
  parameter int P  = 4,
  parameter int OW = 8
) (
  input  logic clk,
  input  logic reset,
  synaptic_current_accumulator_if.slave bus
);

  localparam int AW = W + $clog2(M) + 1;
  localparam int N  = (M + P - 1) / P;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [CW-1:0]        LAST  = CW'(N - 1);
  localparam logic signed [AW-1:0] MAX_V = {{(AW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [AW-1:0] MIN_V = {{(AW-OW+1){1'b1}}, {(OW-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_e;

  state_e                 state_q, state_d;
  logic [M-1:0]           spikes_q, spikes_d;
  logic signed [AW-1:0]   acc_q, acc_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   sat_q, sat_d;
  logic [OW-1:0]          cur_q, cur_d;

  // Zero padding to a whole number of chunks masks the lanes past M.
  logic [N*P-1:0]         spikes_pad;
  logic [N*P*W-1:0]       weights_pad;
  logic [P-1:0]           lane_spk;
  logic [P*W-1:0]         lane_w;
  logic signed [AW-1:0]   chunk_sum;
  logic signed [AW-1:0]   acc_next;
  logic                   over, under;

  always_comb begin
    spikes_pad            = '0;
    spikes_pad[M-1:0]     = spikes_q;
    weights_pad           = '0;
    weights_pad[M*W-1:0]  = bus.weights;
  end

  // Weights are read live each ACCUM cycle; the requester holds them stable while busy.
  always_comb begin
    lane_spk  = P'(spikes_pad >> (cnt_q * P));
    lane_w    = (P*W)'(weights_pad >> (cnt_q * P * W));
    chunk_sum = '0;
    for (int unsigned j = 0; j < P; j++) begin
      if (lane_spk[j]) begin
        chunk_sum = chunk_sum + {{(AW-W){lane_w[j*W+W-1]}}, lane_w[j*W +: W]};
      end
    end
    acc_next = acc_q + chunk_sum;
    over     = (acc_next > MAX_V);
    under    = (acc_next < MIN_V);
  end

  always_comb begin
    state_d  = state_q;
    spikes_d = spikes_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    sat_d    = sat_q;
    cur_d    = cur_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d  = ACCUM;
          spikes_d = bus.input_spikes;
          acc_d    = '0;
          cnt_d    = '0;
          busy_d   = 1'b1;
        end
      end
      ACCUM: begin
        acc_d = acc_next;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = DONE;
          cnt_d   = '0;
          done_d  = 1'b1;
          sat_d   = over | under;
          if (over) begin
            cur_d = MAX_V[OW-1:0];
          end else if (under) begin
            cur_d = MIN_V[OW-1:0];
          end else begin
            cur_d = acc_next[OW-1:0];
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      spikes_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      sat_q    <= 1'b0;
      cur_q    <= '0;
    end else begin
      state_q  <= state_d;
      spikes_q <= spikes_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      sat_q    <= sat_d;
      cur_q    <= cur_d;
    end
  end

  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.input_current = cur_q;
  assign bus.saturated     = sat_q;

endmodule

// File: tb/tb_synaptic_current_accumulator.sv
// Scoreboard bench: default-sized accumulator plus an M=10/P=4 instance with a partial last chunk.
module tb_synaptic_current_accumulator;

  logic clk;
  logic reset;
  int   edge_cnt;
  int   n_pass;
  int   n_total;

  typedef struct {
    logic [7:0] cur;
    logic       sat;
    int         es;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   done_cnt_a, done_cnt_b;
  int   busy_run_a, busy_run_b;
  int   last_done_a;

  synaptic_current_accumulator_if #(.M(24), .W(8), .OW(8)) a_if ();
  synaptic_current_accumulator_if #(.M(10), .W(8), .OW(8)) b_if ();

  synaptic_current_accumulator #(.M(24), .W(8), .P(4), .OW(8)) u_a (
    .clk   (clk),
    .reset (reset),
    .bus   (a_if)
  );

  synaptic_current_accumulator #(.M(10), .W(8), .P(4), .OW(8)) u_b (
    .clk   (clk),
    .reset (reset),
    .bus   (b_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitors: pop an expectation on every done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (reset || !a_if.busy) busy_run_a = 0;
    else busy_run_a++;
    if (a_if.done) begin
      done_cnt_a++;
      last_done_a = edge_cnt;
      if (qa.size() == 0) begin
        check("a_spurious_done", 32'(a_if.done), 0);
      end else begin
        e = qa.pop_front();
        check("a_current", 32'(a_if.input_current), 32'(e.cur));
        check("a_saturated", 32'(a_if.saturated), 32'(e.sat));
        check("a_latency_edges", edge_cnt - e.es + 1, 7);
        check("a_busy_cycles", busy_run_a, 7);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (reset || !b_if.busy) busy_run_b = 0;
    else busy_run_b++;
    if (b_if.done) begin
      done_cnt_b++;
      if (qb.size() == 0) begin
        check("b_spurious_done", 32'(b_if.done), 0);
      end else begin
        e = qb.pop_front();
        check("b_current", 32'(b_if.input_current), 32'(e.cur));
        check("b_saturated", 32'(b_if.saturated), 32'(e.sat));
        check("b_latency_edges", edge_cnt - e.es + 1, 4);
        check("b_busy_cycles", busy_run_b, 4);
      end
    end
  end

  function automatic logic [191:0] fill_w(input logic [7:0] v);
    logic [191:0] r;
    for (int i = 0; i < 24; i++) r[i*8 +: 8] = v;
    return r;
  endfunction

  task automatic issue_a(input logic [23:0] spk, input logic [191:0] wv,
                         input logic [7:0] ecur, input logic esat);
    exp_t e;
    @(negedge clk);
    a_if.input_spikes = spk;
    a_if.weights      = wv;
    a_if.start        = 1'b1;
    e.cur = ecur;
    e.sat = esat;
    e.es  = edge_cnt + 1;
    qa.push_back(e);
    @(negedge clk);
    a_if.start = 1'b0;
  endtask

  task automatic wait_idle_a();
    int i;
    i = 0;
    do begin
      @(negedge clk);
      #1;
      i++;
    end while ((qa.size() != 0 || a_if.busy) && i < 100);
    if (i >= 100) check("a_timeout", 32'(qa.size()) + 32'(a_if.busy), 0);
  endtask

  task automatic run_a(input logic [23:0] spk, input logic [191:0] wv,
                       input logic [7:0] ecur, input logic esat);
    issue_a(spk, wv, ecur, esat);
    wait_idle_a();
  endtask

  initial begin
    logic [191:0] wv;
    logic [79:0]  wb;
    exp_t         e;
    int           d0, d1, i;

    n_pass = 0; n_total = 0;
    done_cnt_a = 0; done_cnt_b = 0;
    busy_run_a = 0; busy_run_b = 0; last_done_a = 0;
    a_if.start = 1'b0; a_if.input_spikes = '0; a_if.weights = '0;
    b_if.start = 1'b0; b_if.input_spikes = '0; b_if.weights = '0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_busy", 32'(a_if.busy), 0);
    check("rst_done", 32'(a_if.done), 0);
    check("rst_current", 32'(a_if.input_current), 0);
    check("rst_saturated", 32'(a_if.saturated), 0);

    // 10 + (-3) = 7
    wv = fill_w(8'd50); wv[0*8 +: 8] = 8'd10; wv[1*8 +: 8] = 8'hFD;
    run_a(24'h000003, wv, 8'd7, 1'b0);
    run_a(24'hFFFFFF, fill_w(8'd100), 8'h7F, 1'b1);
    run_a(24'hFFFFFF, fill_w(8'h9C), 8'h80, 1'b1);
    run_a(24'h000000, fill_w(8'h7F), 8'h00, 1'b0);
    // 20 - 7 + 3 - 1 = 15, all in chunk 2
    wv = fill_w(8'd50);
    wv[8*8 +: 8] = 8'd20; wv[9*8 +: 8] = 8'hF9; wv[10*8 +: 8] = 8'd3; wv[11*8 +: 8] = 8'hFF;
    run_a(24'h000F00, wv, 8'd15, 1'b0);
    wv = fill_w(8'd50); wv[0*8 +: 8] = 8'd100; wv[1*8 +: 8] = 8'd27;
    run_a(24'h000003, wv, 8'h7F, 1'b0);
    wv[1*8 +: 8] = 8'd28;
    run_a(24'h000003, wv, 8'h7F, 1'b1);
    wv = fill_w(8'd50); wv[22*8 +: 8] = 8'hC0; wv[23*8 +: 8] = 8'hC0;
    run_a(24'hC00000, wv, 8'h80, 1'b0);
    wv = fill_w(8'd50); wv[0*8 +: 8] = 8'hFF; wv[23*8 +: 8] = 8'h80;
    run_a(24'h800001, wv, 8'h80, 1'b1);

    // Spikes change and a second start during ACCUM must not matter.
    d0 = done_cnt_a;
    wv = fill_w(8'd50); wv[0*8 +: 8] = 8'd10; wv[1*8 +: 8] = 8'hFD;
    issue_a(24'h000003, wv, 8'd7, 1'b0);
    @(negedge clk);
    a_if.input_spikes = 24'hFFFFFF;
    a_if.start        = 1'b1;
    @(negedge clk);
    a_if.start = 1'b0;
    wait_idle_a();
    repeat (10) @(negedge clk);
    check("ignored_start_done_count", done_cnt_a - d0, 1);

    // Reset during the third ACCUM cycle aborts with no done.
    d0 = done_cnt_a;
    @(negedge clk);
    a_if.input_spikes = 24'hFFFFFF;
    a_if.weights      = fill_w(8'd1);
    a_if.start        = 1'b1;
    @(negedge clk);
    a_if.start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_busy", 32'(a_if.busy), 0);
    check("abort_done", 32'(a_if.done), 0);
    check("abort_current", 32'(a_if.input_current), 0);
    check("abort_saturated", 32'(a_if.saturated), 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    check("abort_no_done", done_cnt_a - d0, 0);
    wv = fill_w(8'd50); wv[0*8 +: 8] = 8'hFB;
    run_a(24'h000001, wv, 8'hFB, 1'b0);

    // Back-to-back: second start in the cycle right after done.
    wv = fill_w(8'd50);
    wv[8*8 +: 8] = 8'd20; wv[9*8 +: 8] = 8'hF9; wv[10*8 +: 8] = 8'd3; wv[11*8 +: 8] = 8'hFF;
    issue_a(24'h000F00, wv, 8'd15, 1'b0);
    i = 0;
    do begin
      @(negedge clk);
      i++;
    end while (!a_if.done && i < 100);
    if (i >= 100) check("b2b_first_done_timeout", 32'(a_if.done), 1);
    d1 = edge_cnt;
    wv = fill_w(8'd50); wv[22*8 +: 8] = 8'hC0; wv[23*8 +: 8] = 8'hC0;
    issue_a(24'hC00000, wv, 8'h80, 1'b0);
    @(negedge clk);
    check("b2b_hold_current", 32'(a_if.input_current), 32'd15);
    check("b2b_hold_saturated", 32'(a_if.saturated), 0);
    wait_idle_a();
    check("b2b_done_spacing", last_done_a - d1, 8);

    // M=10, P=4: weights 1..10, lanes 10 and 11 of the last chunk are padding.
    for (int k = 0; k < 10; k++) wb[k*8 +: 8] = 8'(k + 1);
    @(negedge clk);
    b_if.input_spikes = 10'h3FF;
    b_if.weights      = wb;
    b_if.start        = 1'b1;
    e.cur = 8'd55;
    e.sat = 1'b0;
    e.es  = edge_cnt + 1;
    qb.push_back(e);
    @(negedge clk);
    b_if.start = 1'b0;
    i = 0;
    do begin
      @(negedge clk);
      #1;
      i++;
    end while ((qb.size() != 0 || b_if.busy) && i < 100);
    if (i >= 100) check("b_timeout", 32'(qb.size()) + 32'(b_if.busy), 0);

    repeat (5) @(negedge clk);
    check("a_queue_drained", 32'(qa.size()), 0);
    check("b_done_count", done_cnt_b, 1);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_total);
    $fatal(1);
  end

endmodule

// File: doc/synaptic_current_accumulator.md
SYNAPTIC_CURRENT_ACCUMULATOR -- requirements
Module: synaptic_current_accumulator

Interface
REQ-001 SHALL have parameter M, default 24, number of presynaptic spike inputs and weights.
REQ-002 SHALL have parameter W, default 8, width of each weight, two's-complement signed.
REQ-003 SHALL have parameter P, default 4, lanes summed per cycle, 1 <= P <= M.
REQ-004 SHALL have parameter OW, default 8, signed output current width, OW <= W + clog2(M) + 1.
REQ-005 SHALL have port clk  input  1  clock, rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port start  input  1  request one accumulation, sampled only in IDLE.
REQ-008 SHALL have port input_spikes  input  M  spike vector, bit i gates weight i.
REQ-009 SHALL have port weights  input  M*W  packed signed weights, weight i at bits [i*W +: W].
REQ-010 SHALL have port busy  output  1  high in ACCUM and DONE.
REQ-011 SHALL have port done  output  1  one-cycle pulse, result valid.
REQ-012 SHALL have port input_current  output  OW  saturated signed result, held until next done.
REQ-013 SHALL have port saturated  output  1  high when the last result was clamped, held with input_current.

Function
REQ-014 SHALL implement FSM IDLE -> ACCUM on start; ACCUM -> DONE after the last chunk; DONE -> IDLE unconditionally.
REQ-015 SHALL capture input_spikes into an internal register on the IDLE->ACCUM edge; later input_spikes changes SHALL not affect the result.
REQ-016 SHALL read weights live during ACCUM; requester keeps weights stable while busy (weights not latched, area).
REQ-017 SHALL clear the accumulator on the IDLE->ACCUM edge.
REQ-018 SHALL process N = ceil(M/P) chunks, chunk k covering indices k*P .. k*P+P-1, one chunk per ACCUM cycle, chunk counter 0..N-1.
REQ-019 SHALL mask lanes with index >= M in the final partial chunk to contribute zero.
REQ-020 SHALL sign-extend each gated weight to AW = W + clog2(M) + 1 bits; accumulator SHALL be AW bits and never overflow.
REQ-021 SHALL, on the ACCUM->DONE edge, clamp to [-2^(OW-1), 2^(OW-1)-1], load input_current, set saturated iff clamped.
REQ-022 SHALL assert done for exactly the DONE cycle; done SHALL rise N+1 clock edges after the edge sampling start.
REQ-023 SHALL ignore start while busy; no queuing of requests.
REQ-024 SHALL accept start in the cycle after done (back-to-back throughput one result per N+2 cycles).
REQ-025 SHALL produce input_current = 0, saturated = 0 when no spike bit is set.

Reset
REQ-026 SHALL, on reset assertion, immediately force FSM to IDLE, busy=0, done=0, input_current=0, saturated=0, accumulator, chunk counter and spike register to 0.
REQ-027 SHALL abort any accumulation in progress on reset mid-operation with no done pulse; first start after deassertion begins a fresh accumulation.

Verification
REQ-028 Defaults, spikes=0x000003, w0=10, w1=-3, start one cycle -> done 7 edges later, input_current=7, saturated=0, busy high 7 cycles.
REQ-029 Defaults, all spikes set, all weights=+100 -> input_current=127, saturated=1; all weights=-100 -> input_current=-128, saturated=1.
REQ-030 M=10, P=4, spikes=all ones, weights 1..10 -> 3 chunks, done 4 edges after start, input_current=55, masked lanes contribute nothing.
REQ-031 Change input_spikes and pulse start again during ACCUM -> result reflects original spikes; second start ignored; exactly one done.
REQ-032 Assert reset at third ACCUM cycle -> outputs zero immediately, no done; new start with spikes=0x000001, w0=-5 -> input_current=-5 (0xFB).
REQ-033 Start in cycle after done, two runs back-to-back -> two done pulses 8 cycles apart, each result correct and held between pulses.
